// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounces the start/lap/clear keys, runs the run/pause/lap
// state machine and paces the hh:mm:ss counter with tick and clear pulses.
module stopwatch_ctrl #(
    parameter int TICK_CYC = 500000,
    parameter int DEB_CYC  = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_start_n,
    input  logic        key_lap_n,
    input  logic        key_clear_n,
    input  logic [23:0] live_data,
    output logic        cnt_tick,
    output logic        cnt_clr,
    output logic [23:0] disp_data,
    output logic        run_led,
    output logic        lap_led
);
    localparam int DIV_W = $clog2(TICK_CYC);
    localparam int DEB_W = $clog2(DEB_CYC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] LAP   = 2'd2;
    localparam logic [1:0] PAUSE = 2'd3;

    localparam int K_START = 0;
    localparam int K_LAP   = 1;
    localparam int K_CLEAR = 2;

    logic [2:0]       key_n;
    logic [2:0]       meta;
    logic [2:0]       sync;
    logic [2:0]       last;
    logic [2:0]       level;
    logic [2:0]       press;
    logic [DEB_W-1:0] deb_cnt [3];

    assign key_n = {key_clear_n, key_lap_n, key_start_n};

    // Keys idle high; the counter saturates once the synced level has been stable long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= '1;
            sync  <= '1;
            last  <= '1;
            level <= '1;
            press <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            meta <= key_n;
            sync <= meta;
            last <= sync;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync[i] != last[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] != DEB_LAST) begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end else if (level[i] != last[i]) begin
                    level[i] <= last[i];
                    press[i] <= ~last[i];
                end
            end
        end
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [DIV_W-1:0] div;
    logic [23:0]      lap_reg;
    logic             go_start;
    logic             go_lap;
    logic             go_clear;
    logic             running;
    logic             running_nxt;

    // Only the highest-priority press of a cycle survives; the rest are dropped.
    assign go_clear = press[K_CLEAR];
    assign go_start = press[K_START] & ~press[K_CLEAR];
    assign go_lap   = press[K_LAP] & ~press[K_START] & ~press[K_CLEAR];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go_start) state_nxt = RUN;
            RUN:     if (go_start) state_nxt = PAUSE; else if (go_lap) state_nxt = LAP;
            LAP:     if (go_start) state_nxt = PAUSE; else if (go_lap) state_nxt = RUN;
            PAUSE:   if (go_clear) state_nxt = IDLE;  else if (go_start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    assign running     = (state == RUN) || (state == LAP);
    assign running_nxt = (state_nxt == RUN) || (state_nxt == LAP);

    // A wrap on the same edge that leaves RUN/LAP produces no tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div      <= '0;
            lap_reg  <= '0;
            cnt_tick <= 1'b0;
            cnt_clr  <= 1'b0;
            run_led  <= 1'b0;
            lap_led  <= 1'b0;
        end else begin
            state    <= state_nxt;
            run_led  <= running_nxt;
            lap_led  <= (state_nxt == LAP);
            cnt_tick <= 1'b0;
            cnt_clr  <= go_clear && ((state == IDLE) || (state == PAUSE));
            if (running) begin
                if (div == DIV_LAST) begin
                    div      <= '0;
                    cnt_tick <= running_nxt;
                end else begin
                    div <= div + 1'b1;
                end
            end else if (((state == IDLE) && go_start) || ((state == PAUSE) && go_clear)) begin
                div <= '0;
            end
            if ((state == RUN) && go_lap) lap_reg <= live_data;
        end
    end

    assign disp_data = (state == LAP) ? lap_reg : live_data;

endmodule
